// File: rtl/dlx_pipe_if_if.sv
// Bundle between the DLX IF stage and its neighbours: IM fetch port, ID controls,
// hazard freezes and the IF/ID pipeline register outputs.
// Optional macro DLX_IF_PERF_EN adds the fetch/bubble performance counter outputs.
interface dlx_pipe_if_if;
   logic        stall;
   logic        dc_wait;
   logic [31:0] im_addr;
   logic        im_req;
   logic [31:0] im_rdata;
   logic        im_ready;
   logic        id_cond;
   logic [31:0] id_npc;
   logic        id_halt;
   logic        id_illegal_instr;
   logic [31:0] if_id_npc;
   logic [31:0] if_id_ir;
   logic        if_id_valid;
   logic        if_halted;
   logic        if_exc_illegal;
`ifdef DLX_IF_PERF_EN
   logic [31:0] if_perf_fetch;
   logic [31:0] if_perf_bubble;
`endif

   // IF stage side
   modport master (
      input  stall, dc_wait, im_rdata, im_ready,
             id_cond, id_npc, id_halt, id_illegal_instr,
      output im_addr, im_req, if_id_npc, if_id_ir, if_id_valid,
             if_halted, if_exc_illegal
`ifdef DLX_IF_PERF_EN
      , output if_perf_fetch, if_perf_bubble
`endif
   );

   // Environment side (IM, ID, hazard control)
   modport slave (
      output stall, dc_wait, im_rdata, im_ready,
             id_cond, id_npc, id_halt, id_illegal_instr,
      input  im_addr, im_req, if_id_npc, if_id_ir, if_id_valid,
             if_halted, if_exc_illegal
`ifdef DLX_IF_PERF_EN
      , input if_perf_fetch, if_perf_bubble
`endif
   );
endinterface

// File: rtl/dlx_pipe_if.sv
// DLX instruction-fetch stage: owns the PC, issues IM fetches and registers the
// IF/ID pair, applying ID redirect/halt/illegal controls with NOP bubbles.
// Optional macro DLX_IF_PERF_EN adds saturating fetch/bubble counters.
module dlx_pipe_if #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0015
) (
   input  logic          clk,
   input  logic          rst,
   dlx_pipe_if_if.master bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_HALT = 2'd2} state_t;

   state_t            r_state, w_state_nxt;
   logic [XLEN-1:0]   r_pc, w_pc_nxt;
   logic [XLEN-1:0]   r_ir, w_ir_nxt;
   logic [XLEN-1:0]   r_npc, w_npc_nxt;
   logic              r_valid, w_valid_nxt;
   logic              r_exc, w_exc_nxt;
   logic              r_req;
   logic              r_halted;
   logic              w_freeze;
   logic [XLEN-1:0]   w_pc_inc;
`ifdef DLX_IF_PERF_EN
   logic              w_fetch_inc;
   logic              w_bubble_inc;
   logic [XLEN-1:0]   r_perf_fetch;
   logic [XLEN-1:0]   r_perf_bubble;
`endif

   assign w_freeze = bus.stall | bus.dc_wait;
   assign w_pc_inc = r_pc + XLEN'(4);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state and IF/ID next values, in priority freeze > halt > redirect > fetch > bubble
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_npc_nxt   = r_npc;
      w_valid_nxt = r_valid;
      w_exc_nxt   = r_exc;
`ifdef DLX_IF_PERF_EN
      w_fetch_inc  = 1'b0;
      w_bubble_inc = 1'b0;
`endif
      case (r_state)
         S_IDLE: w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (w_freeze) begin
               w_state_nxt = S_FETCH;
            end else if (bus.id_halt || bus.id_illegal_instr) begin
               w_state_nxt = S_HALT;
               w_ir_nxt    = NOP_INSTR;
               w_valid_nxt = 1'b0;
               w_exc_nxt   = bus.id_illegal_instr;
            end else if (bus.id_cond) begin
               w_pc_nxt    = bus.id_npc;
               w_npc_nxt   = bus.id_npc;
               w_ir_nxt    = NOP_INSTR;
               w_valid_nxt = 1'b0;
`ifdef DLX_IF_PERF_EN
               w_bubble_inc = 1'b1;
`endif
            end else if (bus.im_ready) begin
               w_pc_nxt    = w_pc_inc;
               w_npc_nxt   = w_pc_inc;
               w_ir_nxt    = bus.im_rdata;
               w_valid_nxt = 1'b1;
`ifdef DLX_IF_PERF_EN
               w_fetch_inc = 1'b1;
`endif
            end else begin
               w_ir_nxt    = NOP_INSTR;
               w_valid_nxt = 1'b0;
`ifdef DLX_IF_PERF_EN
               w_bubble_inc = 1'b1;
`endif
            end
         end
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // PC, IF/ID pipeline registers and state-decoded status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc     <= RESET_PC;
         r_ir     <= NOP_INSTR;
         r_npc    <= RESET_PC;
         r_valid  <= 1'b0;
         r_exc    <= 1'b0;
         r_req    <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_pc     <= w_pc_nxt;
         r_ir     <= w_ir_nxt;
         r_npc    <= w_npc_nxt;
         r_valid  <= w_valid_nxt;
         r_exc    <= w_exc_nxt;
         r_req    <= (w_state_nxt == S_FETCH);
         r_halted <= (w_state_nxt == S_HALT);
      end
   end

`ifdef DLX_IF_PERF_EN
   // Saturating fetch/bubble counters; increments only on unfrozen FETCH edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_fetch  <= '0;
         r_perf_bubble <= '0;
      end else begin
         if (w_fetch_inc && (r_perf_fetch != '1))   r_perf_fetch  <= r_perf_fetch + XLEN'(1);
         if (w_bubble_inc && (r_perf_bubble != '1)) r_perf_bubble <= r_perf_bubble + XLEN'(1);
      end
   end

   assign bus.if_perf_fetch  = r_perf_fetch;
   assign bus.if_perf_bubble = r_perf_bubble;
`endif

   assign bus.im_addr        = r_pc;
   assign bus.im_req         = r_req;
   assign bus.if_id_ir       = r_ir;
   assign bus.if_id_npc      = r_npc;
   assign bus.if_id_valid    = r_valid;
   assign bus.if_halted      = r_halted;
   assign bus.if_exc_illegal = r_exc;
endmodule
